// File: rtl/loom_hs_pkg.sv
// loom_hs_pkg: shared width helpers for the handshake FIFO and its pointer registers
// clog2_depth(depth) : bits needed to hold an occupancy of 0..depth
// ptr_width(depth)   : bits needed to index depth entries, never less than 1
package loom_hs_pkg;

    function automatic int clog2_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/handshake_fifo_ptr.sv
// handshake_fifo_ptr: pointer register that wraps to 0 after DEPTH-1
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset, clears ptr to 0
// inc   : advance the pointer this cycle
// ptr   : current pointer value, 0..DEPTH-1
module handshake_fifo_ptr
    import loom_hs_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // Explicit compare keeps non-power-of-two depths correct.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/handshake_fifo.sv
// handshake_fifo: elastic valid/ready FIFO decoupling an operator result from its consumer
// clk       : rising-edge clock
// rst_n     : asynchronous active-low reset; discards all entries
// in_valid  : producer offers in_data
// in_ready  : FIFO accepts this cycle (registered state only, no path from out_ready)
// in_data   : producer data, WIDTH bits
// out_valid : head entry available
// out_ready : consumer accepts head
// out_data  : head entry data, WIDTH bits
// count     : current occupancy, 0..DEPTH
// Optional: define LOOM_FIFO_BYPASS_EN for a zero-latency path when empty.
module handshake_fifo
    import loom_hs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [clog2_depth(DEPTH)-1:0] count
);

    localparam int CW = clog2_depth(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("handshake_fifo: DEPTH must be >= 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             enq;
    logic             deq;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign in_ready = rst_n & ~full;

`ifdef LOOM_FIFO_BYPASS_EN
    // Empty FIFO forwards the producer straight through; storage is only
    // written when the consumer does not take the word in the same cycle.
    assign bypass    = empty & in_valid & out_ready;
    assign out_valid = ~empty | (in_valid & rst_n);
    assign out_data  = empty ? in_data : mem[rd_ptr];
`else
    assign bypass    = 1'b0;
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];
`endif

    assign enq = in_valid & in_ready & ~bypass;
    assign deq = ~empty & out_ready;

    handshake_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enq),
        .ptr   (wr_ptr)
    );

    handshake_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (deq),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (enq)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (enq != deq)
            count <= enq ? count + 1'b1 : count - 1'b1;
    end

endmodule

// File: tb/tb_handshake_fifo.sv
// tb_handshake_fifo: scoreboard bench for handshake_fifo at DEPTH 2 and DEPTH 3
module tb_handshake_fifo;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        iv    [2];
    logic        ir    [2];
    logic [31:0] id    [2];
    logic        ov    [2];
    logic        ordy  [2];
    logic [31:0] od    [2];
    logic [1:0]  cnt   [2];

    logic [31:0] sb [2][$];
    int tests = 0;
    int fails = 0;
    int max_cnt3 = 0;

    always #5 clk = ~clk;

    handshake_fifo #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .count(cnt[0])
    );

    handshake_fifo #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .count(cnt[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every completed output transfer must match the scoreboard head.
    always begin
        @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            if (rst_n[k] && ov[k] && ordy[k]) begin
                if (sb[k].size() == 0) begin
                    chk($sformatf("unexpected_out%0d", k), od[k], 32'hxxxx_xxxx);
                end else begin
                    chk($sformatf("out_data%0d", k), od[k], sb[k].pop_front());
                end
            end
        end
        if (rst_n[1] && 32'(cnt[1]) > max_cnt3)
            max_cnt3 = 32'(cnt[1]);
    end

    // Offers v until accepted; expected word enters the scoreboard once in_ready is seen.
    task automatic push(input int k, input logic [31:0] v);
        int n;
        iv[k] = 1'b1;
        id[k] = v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ir[k] && n < 100);
        chk("push_accept", 32'(ir[k]), 32'd1);
        sb[k].push_back(v);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((sb[k].size() != 0 || ov[k]) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_sb_empty", 32'(sb[k].size()), 32'd0);
        chk("drain_out_valid", 32'(ov[k]), 32'd0);
        chk("drain_count", 32'(cnt[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            iv[k]    = 1'b0;
            id[k]    = '0;
            ordy[k]  = 1'b0;
        end
        iv[0] = 1'b1;
        id[0] = 32'hA5A5_A5A5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(ir[0]), 32'd0);
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_count", 32'(cnt[0]), 32'd0);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(ir[0]), 32'd1);
        chk("rel_out_valid", 32'(ov[0]), 32'd0);
        @(negedge clk);
        chk("rel_count", 32'(cnt[0]), 32'd0);
        @(posedge clk);
        #1;

        // Fill DEPTH 2, hold off a third word, then drain while full.
        push(0, 32'h11);
        push(0, 32'h22);
        chk("full_count", 32'(cnt[0]), 32'd2);
        chk("full_in_ready", 32'(ir[0]), 32'd0);
        iv[0] = 1'b1;
        id[0] = 32'h33;
        @(negedge clk);
        chk("held_in_ready", 32'(ir[0]), 32'd0);
        chk("held_count", 32'(cnt[0]), 32'd2);
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("full_deq_in_ready", 32'(ir[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("after_deq_count", 32'(cnt[0]), 32'd1);
        @(negedge clk);
        chk("reopen_in_ready", 32'(ir[0]), 32'd1);
        sb[0].push_back(32'h33);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("simul_count", 32'(cnt[0]), 32'd1);
        drain(0);

        // DEPTH 3 wrap-around with a half-rate consumer.
        fork
            begin
                for (int v = 1; v <= 10; v++)
                    push(1, 32'(v));
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    ordy[1] = ~ordy[1];
                end
                ordy[1] = 1'b1;
            end
        join
        drain(1);
        chk("d3_max_count", 32'(max_cnt3), 32'd3);

        // Asynchronous reset pulse with two words stored.
        ordy[0] = 1'b0;
        push(0, 32'h44);
        push(0, 32'h55);
        chk("pre_rst_count", 32'(cnt[0]), 32'd2);
        #1;
        rst_n[0] = 1'b0;
        sb[0].delete();
        #1;
        chk("async_out_valid", 32'(ov[0]), 32'd0);
        chk("async_in_ready", 32'(ir[0]), 32'd0);
        chk("async_count", 32'(cnt[0]), 32'd0);
        #4;
        rst_n[0] = 1'b1;
        #1;
        chk("post_rst_count", 32'(cnt[0]), 32'd0);
        chk("post_rst_out_valid", 32'(ov[0]), 32'd0);
        chk("post_rst_in_ready", 32'(ir[0]), 32'd1);
        ordy[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push(0, 32'h66);
        drain(0);

        // Empty FIFO, consumer ready: bypass or one-cycle latency.
        iv[0] = 1'b1;
        id[0] = 32'hDEAD_BEEF;
`ifdef LOOM_FIFO_BYPASS_EN
        #1;
        chk("byp_out_valid", 32'(ov[0]), 32'd1);
        chk("byp_out_data", od[0], 32'hDEAD_BEEF);
        sb[0].push_back(32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("byp_count", 32'(cnt[0]), 32'd0);
        chk("byp_out_valid_after", 32'(ov[0]), 32'd0);
`else
        @(negedge clk);
        chk("lat_out_valid_same", 32'(ov[0]), 32'd0);
        sb[0].push_back(32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("lat_out_valid_next", 32'(ov[0]), 32'd1);
        chk("lat_out_data_next", od[0], 32'hDEAD_BEEF);
        chk("lat_count", 32'(cnt[0]), 32'd1);
`endif
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
